true_dp_bram: RTL and testbench

- Synchronous true dual-port block RAM: two fully independent read/write ports (0 and 1) sharing one storage array and one clock.
- Serves as the generic on-chip buffer primitive for datapath blocks that need concurrent access, e.g. one producer port and one consumer port.
- Intended to infer FPGA block RAM.
- Only the output data registers are reset; array contents are not.

---
 rtl/true_dp_bram_pkg.sv | 13 +
 rtl/bram_port.sv | 56 +++++
 rtl/true_dp_bram.sv | 91 +++++++++
 tb/tb_true_dp_bram.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/true_dp_bram_pkg.sv
// Shared helpers for the true dual-port block RAM.
// Contents:
//   addr_in_range : true when a word address falls inside the storage array.
package true_dp_bram_pkg;

  // Addresses at or above the array depth are out of range. Such a write is
  // dropped, and such a read returns zero.
  function automatic logic addr_in_range(input int unsigned addr,
                                         input int unsigned size);
    return addr < size;
  endfunction

endpackage

// File: rtl/bram_port.sv
// One access port of the true dual-port RAM.
// The port qualifies its own write request and keeps its registered read data.
// The storage array itself lives in the parent module.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset (clears q_o only)
//   ce_i, we_i : chip enable and write enable (we_i is qualified by ce_i)
//   addr_i     : word address
//   rd_data_i  : current array contents at addr_i, before this edge's writes
//   wr_en_o    : qualified write strobe to the array (in range, not in reset)
//   q_o        : registered read data (no-change on writes)
module bram_port
  import true_dp_bram_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 8,
  parameter int MEM_SIZE = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] rd_data_i,
  output logic              wr_en_o,
  output logic [DWIDTH-1:0] q_o
);

  logic              in_range;
  logic [DWIDTH-1:0] q_d;
  logic [DWIDTH-1:0] q_q;

  assign in_range = addr_in_range(32'(addr_i), 32'(MEM_SIZE));

  // Writes are suppressed while in reset so that the array is left untouched.
  assign wr_en_o = ce_i & we_i & in_range & ~rst;

  // A write leaves q unchanged. A read samples the array value from before
  // the edge, so a write from the other port in the same cycle is not visible.
  always_comb begin
    q_d = q_q;
    if (ce_i && !we_i) begin
      q_d = in_range ? rd_data_i : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/true_dp_bram.sv
// Synchronous true dual-port block RAM.
// It has two independent read/write ports that share one array and one clock.
// Both ports read first, and reads are registered (latency 1).
// On a write, a port keeps its q output unchanged.
// If both ports write the same word in the same cycle, port 0 wins.
// Only the q outputs are reset; the array contents are not initialised.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   addr0_i, ce0_i, we0_i, d0_i, q0_o: port 0 address/enable/write/data/read
//   addr1_i, ce1_i, we1_i, d1_i, q1_o: port 1 address/enable/write/data/read
module true_dp_bram #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 8,
  parameter int MEM_SIZE = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] addr0_i,
  input  logic              ce0_i,
  input  logic              we0_i,
  input  logic [DWIDTH-1:0] d0_i,
  output logic [DWIDTH-1:0] q0_o,
  input  logic [AWIDTH-1:0] addr1_i,
  input  logic              ce1_i,
  input  logic              we1_i,
  input  logic [DWIDTH-1:0] d1_i,
  output logic [DWIDTH-1:0] q1_o
);

  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  logic [DWIDTH-1:0] mem [MEM_SIZE];

  logic [IDX_W-1:0]  idx0;
  logic [IDX_W-1:0]  idx1;
  logic [DWIDTH-1:0] rd0;
  logic [DWIDTH-1:0] rd1;
  logic              wr_en0;
  logic              wr_en1;
  logic              wr1_keep;

  // Only in-range addresses ever reach the array through a write strobe.
  // For those addresses, resizing to the index width is lossless.
  assign idx0 = IDX_W'(addr0_i);
  assign idx1 = IDX_W'(addr1_i);
  assign rd0  = mem[idx0];
  assign rd1  = mem[idx1];

  bram_port #(
    .DWIDTH  (DWIDTH),
    .AWIDTH  (AWIDTH),
    .MEM_SIZE(MEM_SIZE)
  ) u_port0 (
    .clk      (clk),
    .rst      (rst),
    .ce_i     (ce0_i),
    .we_i     (we0_i),
    .addr_i   (addr0_i),
    .rd_data_i(rd0),
    .wr_en_o  (wr_en0),
    .q_o      (q0_o)
  );

  bram_port #(
    .DWIDTH  (DWIDTH),
    .AWIDTH  (AWIDTH),
    .MEM_SIZE(MEM_SIZE)
  ) u_port1 (
    .clk      (clk),
    .rst      (rst),
    .ce_i     (ce1_i),
    .we_i     (we1_i),
    .addr_i   (addr1_i),
    .rd_data_i(rd1),
    .wr_en_o  (wr_en1),
    .q_o      (q1_o)
  );

  // When both ports write the same word, port 1's write is dropped.
  assign wr1_keep = wr_en1 & ~(wr_en0 && (idx0 == idx1));

  always_ff @(posedge clk) begin
    if (wr_en0) begin
      mem[idx0] <= d0_i;
    end
    if (wr1_keep) begin
      mem[idx1] <= d1_i;
    end
  end

endmodule

// File: tb/tb_true_dp_bram.sv
module tb_true_dp_bram;

  localparam int DW = 32;
  localparam int AW = 8;
  // Depth below 2**AW so that out-of-range addresses can be reached.
  localparam int MS = 240;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr0, addr1;
  logic          ce0, we0, ce1, we1;
  logic [DW-1:0] d0, d1;
  logic [DW-1:0] q0, q1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  true_dp_bram #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr0_i(addr0),
    .ce0_i  (ce0),
    .we0_i  (we0),
    .d0_i   (d0),
    .q0_o   (q0),
    .addr1_i(addr1),
    .ce1_i  (ce1),
    .we1_i  (we1),
    .d1_i   (d1),
    .q1_o   (q1)
  );

  typedef struct {
    logic          ce0, we0;
    logic [AW-1:0] a0;
    logic [DW-1:0] dd0;
    logic          ce1, we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] dd1;
    logic [DW-1:0] e0, e1;
    string         nm;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a plain word array.
  logic [DW-1:0] mem_m [256];
  logic [DW-1:0] q0_m, q1_m;

  task automatic check(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic c0, input logic w0, input logic [AW-1:0] a0,
                     input logic [DW-1:0] x0, input logic c1, input logic w1,
                     input logic [AW-1:0] a1, input logic [DW-1:0] x1,
                     input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                     input string nm);
    vec_t v;
    v.ce0 = c0; v.we0 = w0; v.a0 = a0; v.dd0 = x0;
    v.ce1 = c1; v.we1 = w1; v.a1 = a1; v.dd1 = x1;
    v.e0 = e0; v.e1 = e1; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic c0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] x0, input logic c1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] x1);
    ce0 = c0; we0 = w0; addr0 = a0; d0 = x0;
    ce1 = c1; we1 = w1; addr1 = a1; d1 = x1;
  endtask

  task automatic cyc(input logic c0, input logic w0, input logic [AW-1:0] a0,
                     input logic [DW-1:0] x0, input logic c1, input logic w1,
                     input logic [AW-1:0] a1, input logic [DW-1:0] x1);
    drive(c0, w0, a0, x0, c1, w1, a1, x1);
    @(posedge clk);
    #1;
  endtask

  // The model follows the behavioural rules directly. Both reads see the
  // contents from before the edge. An out-of-range read returns zero. Port 0
  // wins when both ports write the same word.
  task automatic model_step(input logic c0, input logic w0, input logic [AW-1:0] a0,
                            input logic [DW-1:0] x0, input logic c1, input logic w1,
                            input logic [AW-1:0] a1, input logic [DW-1:0] x1);
    if (c0 && !w0) q0_m = (int'(a0) < MS) ? mem_m[a0] : '0;
    if (c1 && !w1) q1_m = (int'(a1) < MS) ? mem_m[a1] : '0;
    if (c1 && w1 && int'(a1) < MS) mem_m[a1] = x1;
    if (c0 && w0 && int'(a0) < MS) mem_m[a0] = x0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_q0", q0, 32'h0);
    check("reset_q1", q1, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed sequence. Each row is one clock; e0/e1 are the q values after that edge.
    add(1,1,8'h01,32'h00000001, 0,0,8'h00,32'h0, 32'h0, 32'h0, "p0_wr01");
    add(1,1,8'h02,32'h00000002, 0,0,8'h00,32'h0, 32'h0, 32'h0, "p0_wr02");
    for (int i = 0; i < 5; i++)
      add(0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 32'h0, 32'h0, "idle");
    add(1,0,8'h01,32'h0, 0,0,8'h00,32'h0, 32'h00000001, 32'h0, "p0_rd01");
    add(1,0,8'h02,32'h0, 0,0,8'h00,32'h0, 32'h00000002, 32'h0, "p0_rd02");
    add(0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 32'h00000002, 32'h0, "p0_hold");
    add(1,1,8'h03,32'hDEADBEEF, 0,0,8'h00,32'h0, 32'h00000002, 32'h0, "p0_wr_nochg");
    add(0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 32'h00000002, 32'h0, "p0_idle_hold");
    add(0,0,8'h00,32'h0, 1,1,8'h10,32'hAAAAAAAA, 32'h00000002, 32'h0, "p1_pre10");
    add(1,1,8'h10,32'h55555555, 1,0,8'h10,32'h0, 32'h00000002, 32'hAAAAAAAA, "rd_first");
    add(0,0,8'h00,32'h0, 1,0,8'h10,32'h0, 32'h00000002, 32'h55555555, "rd_new");
    add(1,1,8'h20,32'h11111111, 1,1,8'h20,32'h22222222, 32'h00000002, 32'h55555555, "wr_coll");
    add(1,0,8'h20,32'h0, 1,0,8'h20,32'h0, 32'h11111111, 32'h11111111, "coll_rd");
    add(1,0,8'h03,32'h0, 0,0,8'h00,32'h0, 32'hDEADBEEF, 32'h11111111, "rd03");
    add(1,0,8'h01,32'h0, 1,0,8'h01,32'h0, 32'h00000001, 32'h00000001, "both_rd01");
    add(1,1,8'h01,32'h0000CAFE, 0,0,8'h00,32'h0, 32'h00000001, 32'h00000001, "p0_wr01b");
    add(1,0,8'h01,32'h0, 0,0,8'h00,32'h0, 32'h0000CAFE, 32'h00000001, "wr_then_rd");
    add(0,1,8'h01,32'h00000BAD, 0,1,8'h02,32'h00000BAD, 32'h0000CAFE, 32'h00000001, "we_no_ce");
    add(1,1,8'hEF,32'hBEEF0001, 1,1,8'hF0,32'h12345678, 32'h0000CAFE, 32'h00000001, "wr_edge_oor");
    add(1,0,8'hEF,32'h0, 1,0,8'hF0,32'h0, 32'hBEEF0001, 32'h0, "rd_edge_oor");
    add(1,0,8'h01,32'h0, 1,0,8'h02,32'h0, 32'h0000CAFE, 32'h00000002, "we_no_ce_rd");
    add(1,0,8'hFF,32'h0, 0,0,8'h00,32'h0, 32'h0, 32'h00000002, "rd_oor_ff");

    foreach (vecs[i]) begin
      cyc(vecs[i].ce0, vecs[i].we0, vecs[i].a0, vecs[i].dd0,
          vecs[i].ce1, vecs[i].we1, vecs[i].a1, vecs[i].dd1);
      check({vecs[i].nm, "_q0"}, q0, vecs[i].e0);
      check({vecs[i].nm, "_q1"}, q1, vecs[i].e1);
    end

    // Asynchronous reset in the middle of a cycle, with nonzero q values present.
    cyc(1,0,8'h01,32'h0, 1,0,8'h02,32'h0);
    check("pre_rst_q0", q0, 32'h0000CAFE);
    check("pre_rst_q1", q1, 32'h00000002);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_q0", q0, 32'h0);
    check("async_rst_q1", q1, 32'h0);
    drive(1,1,8'h01,32'h00000BAD, 1,0,8'h02,32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_q0", q0, 32'h0);
    check("rst_hold_q1", q1, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0,0,'0,'0, 0,0,'0,'0);
    #1;
    check("rel_q0", q0, 32'h0);
    cyc(1,0,8'h01,32'h0, 1,0,8'h02,32'h0);
    check("rst_mem01", q0, 32'h0000CAFE);
    check("rst_mem02", q1, 32'h00000002);

    // Fill every in-range word so that later random reads are all defined.
    q0_m = 32'h0000CAFE;
    q1_m = 32'h00000002;
    for (int a = 0; a < MS; a++) begin
      logic [DW-1:0] v;
      v = $urandom;
      model_step(1, 1, AW'(a), v, 0, 0, '0, '0);
      cyc(1, 1, AW'(a), v, 0, 0, '0, '0);
    end
    check("fill_hold_q0", q0, q0_m);

    // Concurrent independent traffic: port 0 writes while port 1 reads a different word.
    for (int i = 0; i < 16; i++) begin
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] v;
      wa = AW'($urandom_range(0, MS - 1));
      ra = AW'($urandom_range(0, MS - 1));
      if (ra == wa) ra = AW'((int'(wa) + 1) % MS);
      v = $urandom;
      model_step(1, 1, wa, v, 1, 0, ra, '0);
      cyc(1, 1, wa, v, 1, 0, ra, '0);
      check("conc_q0", q0, q0_m);
      check("conc_q1", q1, q1_m);
    end

    // Random traffic on both ports. It includes out-of-range addresses and same-address collisions.
    for (int i = 0; i < 400; i++) begin
      logic c0, w0, c1, w1;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] x0, x1;
      c0 = ($urandom_range(0, 3) != 0);
      c1 = ($urandom_range(0, 3) != 0);
      w0 = $urandom_range(0, 1) == 1;
      w1 = $urandom_range(0, 1) == 1;
      a0 = AW'($urandom_range(0, 255));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, 255));
      x0 = $urandom;
      x1 = $urandom;
      model_step(c0, w0, a0, x0, c1, w1, a1, x1);
      cyc(c0, w0, a0, x0, c1, w1, a1, x1);
      check("rand_q0", q0, q0_m);
      check("rand_q1", q1, q1_m);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
